// File: rtl/cva6_ras_pkg.sv
// Shared types and wrap-around pointer helpers for the CVA6 return-address stack.
package cva6_ras_pkg;

    localparam int unsigned RAS_MAX_DEPTH = 64;
    localparam int unsigned RAS_MAX_PTRW  = $clog2(RAS_MAX_DEPTH);
    localparam int unsigned RAS_MAX_CNTW  = $clog2(RAS_MAX_DEPTH + 1);
    localparam int unsigned RAS_MAX_VLEN  = 64;

    typedef struct packed {
        logic [RAS_MAX_PTRW-1:0] ptr;
        logic [RAS_MAX_CNTW-1:0] cnt;
        logic [RAS_MAX_VLEN-1:0] top;
    } ras_ckpt_t;

    // Modular step without assuming Depth is a power of two.
    function automatic int unsigned ras_inc(input int unsigned p,
                                            input int unsigned depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

    function automatic int unsigned ras_dec(input int unsigned p,
                                            input int unsigned depth);
        return (p == 0) ? depth - 1 : p - 1;
    endfunction

endpackage

// File: rtl/cva6_ras_ckpt.sv
// Parametrised return-address stack with wrap, replace, status pulses and
// checkpoint restore; restore is enabled by defining CVA6_RAS_CKPT_EN.
module cva6_ras_ckpt
    import cva6_ras_pkg::*;
#(
    parameter int unsigned VLEN  = 32,
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    output logic            valid_o,
    output logic [VLEN-1:0] ra_o,
    output logic [CntW-1:0] count_o,
    output logic [PtrW-1:0] ckpt_ptr_o,
    output logic            overflow_o,
    output logic            underflow_o,
    input  logic            restore_i,
    input  logic [PtrW-1:0] restore_ptr_i,
    input  logic [CntW-1:0] restore_cnt_i,
    input  logic [VLEN-1:0] restore_top_i
);

    localparam logic [CntW-1:0] FULL = CntW'(Depth);

    logic [VLEN-1:0] mem_q [Depth];
    logic [VLEN-1:0] mem_d [Depth];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [PtrW-1:0] ptr_inc, ptr_dec;

    assign ptr_inc = PtrW'(ras_inc(32'(ptr_q), Depth));
    assign ptr_dec = PtrW'(ras_dec(32'(ptr_q), Depth));

    logic            do_restore;
    logic [CntW-1:0] rcnt;

`ifdef CVA6_RAS_CKPT_EN
    assign do_restore = restore_i;
    assign rcnt       = (restore_cnt_i > FULL) ? FULL : restore_cnt_i;
    assign ckpt_ptr_o = ptr_q;
`else
    logic unused_restore;
    assign unused_restore = ^{restore_i, restore_ptr_i,
                              restore_cnt_i, restore_top_i};
    assign do_restore = 1'b0;
    assign rcnt       = '0;
    assign ckpt_ptr_o = '0;
`endif

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (flush_bp_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (do_restore) begin
`ifdef CVA6_RAS_CKPT_EN
            ptr_d = restore_ptr_i;
            cnt_d = rcnt;
            for (int i = 0; i < int'(Depth); i++) begin
                if (PtrW'(i) == restore_ptr_i) mem_d[i] = restore_top_i;
            end
`endif
        end else if (push_i && (!pop_i || cnt_q == '0)) begin
            ptr_d          = ptr_inc;
            mem_d[ptr_inc] = data_i;
            if (cnt_q == FULL) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end else if (push_i && pop_i) begin
            // Call and return in one fetch block: the top is simply replaced.
            mem_d[ptr_q] = data_i;
        end else if (pop_i) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign valid_o     = (cnt_q != '0);
    assign ra_o        = mem_q[ptr_q];
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// Scoreboard bench for cva6_ras_ckpt with VLEN=32, Depth=2.
module tb_cva6_ras_ckpt;
    import cva6_ras_pkg::*;

`ifdef CVA6_RAS_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] data = '0;
    logic        valid;
    logic [31:0] ra;
    logic [1:0]  count;
    logic [0:0]  ckpt_ptr;
    logic        ovf;
    logic        unf;
    logic        restore = 1'b0;
    logic [0:0]  rptr = '0;
    logic [1:0]  rcnt = '0;
    logic [31:0] rtop = '0;

    always #5 clk = ~clk;

    cva6_ras_ckpt #(.VLEN(32), .Depth(2)) dut (
        .clk_i(clk), .rst_i(rst), .flush_bp_i(flush),
        .push_i(push), .pop_i(pop), .data_i(data),
        .valid_o(valid), .ra_o(ra), .count_o(count),
        .ckpt_ptr_o(ckpt_ptr), .overflow_o(ovf), .underflow_o(unf),
        .restore_i(restore), .restore_ptr_i(rptr),
        .restore_cnt_i(rcnt), .restore_top_i(rtop)
    );

    typedef struct {
        logic        v;
        logic [31:0] ra;
        logic [1:0]  cnt;
        logic [0:0]  ptr;
        logic        o;
        logic        u;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Monitor: outputs are registered, so compare each negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            logic [0:0] ep;
            e  = exp_q.pop_front();
            n  = name_q.pop_front();
            ep = CK ? e.ptr : 1'b0;
            checks++;
            if (valid !== e.v || ra !== e.ra || count !== e.cnt ||
                ckpt_ptr !== ep || ovf !== e.o || unf !== e.u) begin
                errors++;
                $display("FAIL %s: got v=%0b ra=%h cnt=%0d ptr=%0d ovf=%0b unf=%0b, want v=%0b ra=%h cnt=%0d ptr=%0d ovf=%0b unf=%0b",
                         n, valid, ra, count, ckpt_ptr, ovf, unf,
                         e.v, e.ra, e.cnt, ep, e.o, e.u);
            end
        end
    end

    task automatic cyc(input string nm,
                       input logic r, input logic fl,
                       input logic pu, input logic po,
                       input logic [31:0] d, input logic rs,
                       input ras_ckpt_t ck,
                       input logic ev, input logic [31:0] era,
                       input logic [1:0] ecnt, input logic [0:0] eptr,
                       input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst     = r;
        flush   = fl;
        push    = pu;
        pop     = po;
        data    = d;
        restore = rs;
        rptr    = ck.ptr[0:0];
        rcnt    = ck.cnt[1:0];
        rtop    = ck.top[31:0];
        @(posedge clk);
        #1;
        e = '{v: ev, ra: era, cnt: ecnt, ptr: eptr, o: eo, u: eu};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    ras_ckpt_t nc;
    ras_ckpt_t snap;
    ras_ckpt_t big;

    initial begin
        nc   = '0;
        snap = '{ptr: 6'd1, cnt: 7'd1, top: 64'h10};
        big  = '{ptr: 6'd0, cnt: 7'd3, top: 64'h55};

        //      name       rst fl pu po data         rs ck   v  ra           c  p  o  u
        cyc("reset",      1, 0, 0, 0, 32'h0,        0, nc,  0, 32'h0,        0, 0, 0, 0);
        cyc("push1",      0, 0, 1, 0, 32'h8000_0010, 0, nc, 1, 32'h8000_0010, 1, 1, 0, 0);
        cyc("push2",      0, 0, 1, 0, 32'h8000_0020, 0, nc, 1, 32'h8000_0020, 2, 0, 0, 0);
        cyc("pop1",       0, 0, 0, 1, 32'h0,        0, nc,  1, 32'h8000_0010, 1, 1, 0, 0);
        cyc("pop2",       0, 0, 0, 1, 32'h0,        0, nc,  0, 32'h8000_0020, 0, 0, 0, 0);

        cyc("ovf_pushA",  0, 0, 1, 0, 32'h10,       0, nc,  1, 32'h10,       1, 1, 0, 0);
        cyc("ovf_pushB",  0, 0, 1, 0, 32'h20,       0, nc,  1, 32'h20,       2, 0, 0, 0);
        cyc("ovf_pushC",  0, 0, 1, 0, 32'h30,       0, nc,  1, 32'h30,       2, 1, 1, 0);
        cyc("ovf_pop1",   0, 0, 0, 1, 32'h0,        0, nc,  1, 32'h20,       1, 0, 0, 0);
        cyc("ovf_pop2",   0, 0, 0, 1, 32'h0,        0, nc,  0, 32'h30,       0, 1, 0, 0);

        cyc("rep_push",   0, 0, 1, 0, 32'h10,       0, nc,  1, 32'h10,       1, 0, 0, 0);
        cyc("replace",    0, 0, 1, 1, 32'h44,       0, nc,  1, 32'h44,       1, 0, 0, 0);

        cyc("ck_flush",   0, 1, 0, 0, 32'h0,        0, nc,  0, 32'h44,       0, 0, 0, 0);
        cyc("ck_push",    0, 0, 1, 0, 32'h10,       0, nc,  1, 32'h10,       1, 1, 0, 0);
        cyc("ck_pop",     0, 0, 0, 1, 32'h0,        0, nc,  0, 32'h44,       0, 0, 0, 0);
        cyc("ck_push99",  0, 0, 1, 0, 32'h99,       0, nc,  1, 32'h99,       1, 1, 0, 0);
        if (CK)
            cyc("restore", 0, 0, 1, 0, 32'h77,      1, snap, 1, 32'h10,      1, 1, 0, 0);
        else
            cyc("restore", 0, 0, 0, 0, 32'h0,       1, snap, 1, 32'h99,      1, 1, 0, 0);

        cyc("fl_flush",   0, 1, 0, 0, 32'h0,        0, nc,  0, 32'h44,       0, 0, 0, 0);
        cyc("underflow",  0, 0, 0, 1, 32'h0,        0, nc,  0, 32'h44,       0, 0, 0, 1);
        cyc("push_flush", 0, 1, 1, 0, 32'h66,       0, nc,  0, 32'h44,       0, 0, 0, 0);
        cyc("rs_flush",   0, 1, 0, 0, 32'h0,        1, snap, 0, 32'h44,      0, 0, 0, 0);
        if (CK)
            cyc("rs_clamp", 0, 0, 0, 0, 32'h0,      1, big, 1, 32'h55,       2, 0, 0, 0);
        else
            cyc("rs_clamp", 0, 0, 0, 0, 32'h0,      1, big, 0, 32'h44,       0, 0, 0, 0);
        cyc("reset2",     1, 0, 1, 0, 32'hAA,       0, nc,  0, 32'h0,        0, 0, 0, 0);
        cyc("post_rst",   0, 0, 1, 0, 32'hAB,       0, nc,  1, 32'hAB,       1, 1, 0, 0);

        begin
            int n = 0;
            @(negedge clk);
            rst = 0; flush = 0; push = 0; pop = 0; restore = 0;
            while (exp_q.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
